// File: rtl/frv_gprs_pkg.sv
// Shared types for the parametrised GPR file: clear-engine state encoding
// and the pair-index width helper.
package frv_gprs_pkg;

   typedef enum logic [1:0] {
      CLR_IDLE  = 2'd0,
      CLR_CLEAR = 2'd1,
      CLR_DONE  = 2'd2
   } clr_state_t;

   // Width of an index selecting one even/odd register pair.
   function automatic int unsigned pair_idx_w(input int unsigned aw);
      return (aw > 1) ? aw - 1 : 1;
   endfunction

endpackage

// File: rtl/frv_gprs_clr_fsm.sv
// Scrub sequencer: walks every register pair once, then pulses clr_done.
// Busy for the whole walk plus the DONE cycle.
module frv_gprs_clr_fsm
   import frv_gprs_pkg::*;
#(
   parameter int unsigned AW = 5
) (
   input  logic                       g_clk,
   input  logic                       g_resetn,
   input  logic                       clr_req,
   output logic                       clr_busy,
   output logic                       clr_done,
   output logic                       clr_wen,
   output logic [pair_idx_w(AW)-1:0]  clr_idx
);

   localparam int unsigned PW = pair_idx_w(AW);

   clr_state_t      state, state_n;
   logic [PW-1:0]   idx, idx_n;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state <= CLR_IDLE;
         idx   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
      end
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      clr_wen  = 1'b0;
      clr_done = 1'b0;
      case (state)
         CLR_IDLE: begin
            if (clr_req) begin
               state_n = CLR_CLEAR;
               idx_n   = '0;
            end
         end
         CLR_CLEAR: begin
            clr_wen = 1'b1;
            idx_n   = idx + PW'(1);
            // Pair count is a power of two, so all-ones marks the last pair.
            if (idx == '1) state_n = CLR_DONE;
         end
         CLR_DONE: begin
            clr_done = 1'b1;
            state_n  = CLR_IDLE;
         end
         default: state_n = CLR_IDLE;
      endcase
   end

   assign clr_busy = (state != CLR_IDLE);
   assign clr_idx  = idx;

endmodule

// File: rtl/frv_gprs_param.sv
// Parametrised even/odd paired GPR file with wide writes, per-pair reverse
// flags, optional write-to-read bypass and a sequential scrub engine.
module frv_gprs_param
   import frv_gprs_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned AW         = 5,
   parameter int unsigned NREAD      = 3,
   parameter int unsigned BYPASS     = 0,
   parameter int unsigned CLR_RANDOM = 1
) (
   input  logic                    g_clk,
   input  logic                    g_resetn,
   input  logic [NREAD*AW-1:0]     rs_addr,
   output logic [NREAD*XLEN-1:0]   rs_data,
   output logic [NREAD*XLEN-1:0]   rs_rdhi,
   output logic [NREAD-1:0]        rs_lo_rev,
   output logic [NREAD-1:0]        rs_hi_rev,
   input  logic                    rd_wen,
   input  logic                    rd_wide,
   input  logic [AW-1:0]           rd_addr,
   input  logic [XLEN-1:0]         rd_wdata,
   input  logic [XLEN-1:0]         rd_wdata_hi,
   input  logic                    rd_wdata_hi_rev,
   input  logic                    clr_req,
   input  logic [XLEN-1:0]         clr_rnd,
   output logic                    clr_busy,
   output logic                    clr_done
);

   localparam int unsigned PW    = pair_idx_w(AW);
   localparam int unsigned NPAIR = 2 ** (AW - 1);

   logic [XLEN-1:0]  even_q [NPAIR];
   logic [XLEN-1:0]  odd_q  [NPAIR];
   logic [NPAIR-1:0] rev_q;

   logic             clr_wen;
   logic [PW-1:0]    clr_idx;
   logic [XLEN-1:0]  clr_val;

   logic             wr_ok, wr_even, wr_odd;
   logic [PW-1:0]    wr_pidx;
   logic [XLEN-1:0]  wr_odd_data;

   frv_gprs_clr_fsm #(.AW(AW)) u_clr_fsm (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_wen  (clr_wen),
      .clr_idx  (clr_idx)
   );

   assign clr_val     = (CLR_RANDOM != 0) ? clr_rnd : '0;
   assign wr_ok       = rd_wen && !clr_busy;
   assign wr_pidx     = PW'(rd_addr >> 1);
   // x0 is the even half of pair 0; excluding it here also keeps it out of the bypass.
   assign wr_even     = wr_ok && !rd_addr[0] && (wr_pidx != '0);
   assign wr_odd      = wr_ok && (rd_addr[0] || rd_wide);
   assign wr_odd_data = rd_wide ? rd_wdata_hi : rd_wdata;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         for (int unsigned i = 0; i < NPAIR; i++) begin
            even_q[i] <= '0;
            odd_q[i]  <= '0;
         end
         rev_q <= '0;
      end else if (clr_wen) begin
         if (clr_idx != '0) even_q[clr_idx] <= clr_val;
         odd_q[clr_idx] <= clr_val;
         rev_q[clr_idx] <= 1'b0;
      end else begin
         if (wr_even) even_q[wr_pidx] <= rd_wdata;
         if (wr_odd) begin
            odd_q[wr_pidx] <= wr_odd_data;
            rev_q[wr_pidx] <= rd_wdata_hi_rev;
         end
      end
   end

   always_comb begin
      logic [AW-1:0]   ra;
      logic [PW-1:0]   pi;
      logic [XLEN-1:0] ev, od;
      logic            rv;
      rs_data   = '0;
      rs_rdhi   = '0;
      rs_lo_rev = '0;
      rs_hi_rev = '0;
      ra = '0;
      pi = '0;
      ev = '0;
      od = '0;
      rv = 1'b0;
      for (int unsigned p = 0; p < NREAD; p++) begin
         ra = rs_addr[p*AW +: AW];
         pi = PW'(ra >> 1);
         ev = even_q[pi];
         od = odd_q[pi];
         rv = rev_q[pi];
         if (BYPASS != 0) begin
            if (wr_even && (wr_pidx == pi)) ev = rd_wdata;
            if (wr_odd && (wr_pidx == pi)) begin
               od = wr_odd_data;
               rv = rd_wdata_hi_rev;
            end
         end
         rs_data[p*XLEN +: XLEN] = ra[0] ? od : ev;
         rs_rdhi[p*XLEN +: XLEN] = od;
         rs_lo_rev[p]            = ra[0] & rv;
         rs_hi_rev[p]            = rv;
      end
   end

endmodule

// File: tb/tb_frv_gprs_param.sv
// Randomised bench for frv_gprs_param: a BYPASS=0 and a BYPASS=1 instance
// share stimulus and are checked against an architectural register model.
module tb_frv_gprs_param;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NREAD = 3;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NPAIR = 16;

   logic                  g_clk = 1'b0;
   logic                  g_resetn;
   logic [NREAD*AW-1:0]   rs_addr;
   logic                  rd_wen, rd_wide, rd_wdata_hi_rev, clr_req;
   logic [AW-1:0]         rd_addr;
   logic [XLEN-1:0]       rd_wdata, rd_wdata_hi, clr_rnd;

   logic [NREAD*XLEN-1:0] nb_rs_data, nb_rs_rdhi, bp_rs_data, bp_rs_rdhi;
   logic [NREAD-1:0]      nb_rs_lo_rev, nb_rs_hi_rev, bp_rs_lo_rev, bp_rs_hi_rev;
   logic                  nb_busy, nb_done, bp_busy, bp_done;

   always #5 g_clk = ~g_clk;

   frv_gprs_param #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD), .BYPASS(0), .CLR_RANDOM(1)) dut_nb (
      .g_clk(g_clk), .g_resetn(g_resetn), .rs_addr(rs_addr),
      .rs_data(nb_rs_data), .rs_rdhi(nb_rs_rdhi), .rs_lo_rev(nb_rs_lo_rev), .rs_hi_rev(nb_rs_hi_rev),
      .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
      .rd_wdata_hi(rd_wdata_hi), .rd_wdata_hi_rev(rd_wdata_hi_rev),
      .clr_req(clr_req), .clr_rnd(clr_rnd), .clr_busy(nb_busy), .clr_done(nb_done)
   );

   frv_gprs_param #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD), .BYPASS(1), .CLR_RANDOM(1)) dut_bp (
      .g_clk(g_clk), .g_resetn(g_resetn), .rs_addr(rs_addr),
      .rs_data(bp_rs_data), .rs_rdhi(bp_rs_rdhi), .rs_lo_rev(bp_rs_lo_rev), .rs_hi_rev(bp_rs_hi_rev),
      .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
      .rd_wdata_hi(rd_wdata_hi), .rd_wdata_hi_rev(rd_wdata_hi_rev),
      .clr_req(clr_req), .clr_rnd(clr_rnd), .clr_busy(bp_busy), .clr_done(bp_done)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Architectural model: mx holds x0..x31, mrev one flag per pair.
   // phase: -1 idle, 0..NPAIR-1 scrubbing that pair, NPAIR done cycle.
   logic [XLEN-1:0] mx [NREGS];
   bit              mrev [NPAIR];
   logic [XLEN-1:0] bx [NREGS];
   bit              brev [NPAIR];
   int              phase;
   int unsigned     cyc;
   int unsigned     busy_cnt, done_cnt;

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) mx[i] = '0;
      for (int i = 0; i < NPAIR; i++) mrev[i] = 1'b0;
      phase = -1;
   endtask

   // bx/brev: architectural state as it will be once this cycle's write lands.
   task automatic build_view();
      bx   = mx;
      brev = mrev;
      if (rd_wen && phase < 0) begin
         if (!rd_addr[0] && rd_addr != '0) bx[rd_addr] = rd_wdata;
         if (rd_addr[0] || rd_wide) begin
            bx[{rd_addr[AW-1:1], 1'b1}] = rd_wide ? rd_wdata_hi : rd_wdata;
            brev[rd_addr >> 1] = rd_wdata_hi_rev;
         end
      end
   endtask

   task automatic check_outputs();
      logic [AW-1:0] a;
      int unsigned   pr;
      build_view();
      check("busy_nb", nb_busy, phase >= 0);
      check("busy_bp", bp_busy, phase >= 0);
      check("done_nb", nb_done, phase == NPAIR);
      check("done_bp", bp_done, phase == NPAIR);
      for (int p = 0; p < NREAD; p++) begin
         a  = rs_addr[p*AW +: AW];
         pr = a >> 1;
         check($sformatf("nb_data p%0d x%0d", p, a), nb_rs_data[p*XLEN +: XLEN], mx[a]);
         check($sformatf("nb_rdhi p%0d x%0d", p, a), nb_rs_rdhi[p*XLEN +: XLEN], mx[{a[AW-1:1], 1'b1}]);
         check($sformatf("nb_rev p%0d x%0d", p, a), {nb_rs_hi_rev[p], nb_rs_lo_rev[p]},
               {mrev[pr], a[0] & mrev[pr]});
         check($sformatf("bp_data p%0d x%0d", p, a), bp_rs_data[p*XLEN +: XLEN], bx[a]);
         check($sformatf("bp_rdhi p%0d x%0d", p, a), bp_rs_rdhi[p*XLEN +: XLEN], bx[{a[AW-1:1], 1'b1}]);
         check($sformatf("bp_rev p%0d x%0d", p, a), {bp_rs_hi_rev[p], bp_rs_lo_rev[p]},
               {brev[pr], a[0] & brev[pr]});
      end
   endtask

   task automatic update_model();
      if (phase >= 0 && phase < NPAIR) begin
         if (phase != 0) mx[2*phase] = clr_rnd;
         mx[2*phase+1] = clr_rnd;
         mrev[phase]   = 1'b0;
         phase++;
      end else if (phase == NPAIR) begin
         phase = -1;
      end else begin
         mx   = bx;
         mrev = brev;
         if (clr_req) phase = 0;
      end
   endtask

   // Called at a falling edge with inputs set; returns at the next falling edge.
   task automatic step();
      clr_rnd = cyc;
      #1;
      check_outputs();
      @(posedge g_clk);
      update_model();
      cyc++;
      @(negedge g_clk);
   endtask

   task automatic set_rd(input int a0, input int a1, input int a2);
      rs_addr = {AW'(a2), AW'(a1), AW'(a0)};
   endtask

   task automatic rand_inputs();
      logic [AW-1:0] r;
      rd_wen          = 1'($urandom_range(0, 1));
      rd_wide         = 1'($urandom_range(0, 1));
      rd_addr         = AW'($urandom);
      rd_wdata        = $urandom;
      rd_wdata_hi     = $urandom;
      rd_wdata_hi_rev = 1'($urandom_range(0, 1));
      for (int p = 0; p < NREAD; p++) begin
         r = AW'($urandom);
         case ($urandom_range(0, 3))
            0:       rs_addr[p*AW +: AW] = rd_addr;
            1:       rs_addr[p*AW +: AW] = rd_addr ^ AW'(1);
            default: rs_addr[p*AW +: AW] = r;
         endcase
      end
   endtask

   task automatic populate();
      for (int a = 1; a < NREGS; a++) begin
         rd_wen = 1'b1; rd_wide = 1'b0; rd_addr = AW'(a);
         rd_wdata = $urandom | 32'h1; rd_wdata_hi_rev = 1'($urandom_range(0, 1));
         set_rd(a, a ^ 1, 31 - a);
         step();
      end
      rd_wen = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      g_resetn = 1'b0; rs_addr = '0; rd_wen = 1'b0; rd_wide = 1'b0; rd_addr = '0;
      rd_wdata = '0; rd_wdata_hi = '0; rd_wdata_hi_rev = 1'b0; clr_req = 1'b0; clr_rnd = '0;
      cyc = 0;
      model_reset();
      repeat (2) @(negedge g_clk);
      set_rd(3, 1, 31);
      #1;
      check("rst_busy", nb_busy, 0);
      check("rst_done", nb_done, 0);
      check("rst_data", nb_rs_data, 0);
      check("rst_revs", {nb_rs_hi_rev, nb_rs_lo_rev}, 0);
      @(negedge g_clk);
      g_resetn = 1'b1;
      step();

      // Narrow write x5, read it and its pair partner.
      rd_wen = 1'b1; rd_addr = 5; rd_wdata = 32'hDEADBEEF; set_rd(4, 0, 5);
      step();
      rd_wen = 1'b0;
      #1;
      check("x5_p2_data", nb_rs_data[2*XLEN +: XLEN], 32'hDEADBEEF);
      check("x5_p2_lorev", nb_rs_lo_rev[2], 0);
      check("x4_p0_rdhi", nb_rs_rdhi[0 +: XLEN], 32'hDEADBEEF);
      step();

      // Wide write to pair x6/x7 with reversed high word.
      rd_wen = 1'b1; rd_wide = 1'b1; rd_addr = 6; rd_wdata = 32'h11111111;
      rd_wdata_hi = 32'h22222222; rd_wdata_hi_rev = 1'b1;
      step();
      rd_wen = 1'b0; rd_wide = 1'b0; rd_wdata_hi_rev = 1'b0; set_rd(6, 7, 0);
      #1;
      check("x6_data", nb_rs_data[0 +: XLEN], 32'h11111111);
      check("x6_rdhi", nb_rs_rdhi[0 +: XLEN], 32'h22222222);
      check("x6_revs", {nb_rs_hi_rev[0], nb_rs_lo_rev[0]}, 2'b10);
      check("x7_data", nb_rs_data[XLEN +: XLEN], 32'h22222222);
      check("x7_lorev", nb_rs_lo_rev[1], 1);
      step();

      // x0 is immune to narrow writes; wide write to 0 lands only in x1.
      rd_wen = 1'b1; rd_addr = 0; rd_wdata = 32'hFFFFFFFF;
      step();
      rd_wide = 1'b1; rd_wdata_hi = 32'hA5A5A5A5;
      step();
      rd_wen = 1'b0; rd_wide = 1'b0; set_rd(0, 1, 0);
      #1;
      check("x0_zero", nb_rs_data[0 +: XLEN], 0);
      check("x1_wide", nb_rs_data[XLEN +: XLEN], 32'hA5A5A5A5);
      step();

      // Same-cycle read of a register under write.
      rd_wen = 1'b1; rd_addr = 9; rd_wdata = 32'hCAFE0000;
      step();
      rd_wdata = 32'h12345678; set_rd(0, 9, 0);
      #1;
      check("bypass_on_x9", bp_rs_data[XLEN +: XLEN], 32'h12345678);
      check("bypass_off_x9", nb_rs_data[XLEN +: XLEN], 32'hCAFE0000);
      step();
      rd_wen = 1'b0;

      // Random traffic with occasional scrub requests.
      for (int i = 0; i < 300; i++) begin
         rand_inputs();
         clr_req = ($urandom_range(0, 63) == 0);
         step();
      end
      clr_req = 1'b0; rd_wen = 1'b0;
      repeat (NPAIR + 2) step();

      // Full scrub over populated registers, with writes attempted throughout.
      populate();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (nb_busy) busy_cnt++;
         if (nb_done) done_cnt++;
         rand_inputs();
         if (i >= 17) rd_wen = 1'b0;
         step();
      end
      check("scrub_busy_cycles", busy_cnt, NPAIR + 1);
      check("scrub_done_pulses", done_cnt, 1);
      rd_wen = 1'b0;
      for (int a = 0; a < NREGS; a++) begin
         set_rd(a, 31 - a, a ^ 1);
         step();
      end

      // Reset asserted in CLEAR cycle 5.
      populate();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (5) step();
      check("pre_rst_busy", nb_busy, 1);
      g_resetn = 1'b0;
      model_reset();
      set_rd(5, 6, 31);
      #1;
      check("midrst_busy", nb_busy, 0);
      check("midrst_done", nb_done, 0);
      check("midrst_data", nb_rs_data, 0);
      check("midrst_rdhi", nb_rs_rdhi, 0);
      step();
      g_resetn = 1'b1;
      done_cnt = 0;
      for (int a = 0; a < NREGS; a++) begin
         if (nb_done) done_cnt++;
         set_rd(a, a ^ 1, 31 - a);
         step();
      end
      check("midrst_no_done", done_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
